calc_accumulator: RTL and testbench
===================================

Name: calc_accumulator

Overview:
Sequencing stage that sits directly upstream of the existing signed `adder` and consumes its result. It accepts calculator commands over a valid/ready interface and drives the adder's `a` and `b` operands from an internal accumulator and the command data. It latches the adder's `sum`/`overflow` back into the accumulator and returns each result over a valid/ready response interface. It is the state-holding core of the calc datapath between command decode and display/readout.

Parameters:
WIDTH, 32, operand/accumulator width in bits; the adder is instantiated at this width.
SATURATE, 0, 0 = wrap on overflow; 1 = clamp accumulator to signed max/min on overflow.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command
cmd_op  input  2  00 LOAD, 01 ADD, 10 SUB, 11 CLEAR
cmd_data  input  WIDTH  signed operand (ignored for CLEAR)
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_data  output  WIDTH  signed accumulator value after the command
rsp_overflow  output  1  this command overflowed
sticky_ov  output  1  any overflow since last CLEAR/reset
acc_value  output  WIDTH  current accumulator, always visible

Behaviour:
- Clocking/reset: one clock (`clk`); reset is synchronous and active-high (`rst`).
- Reset values: state=IDLE, acc=0, sticky_ov=0, cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_overflow=0. Reset mid-operation discards any in-flight command and any pending response.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: cmd_ready=1. On cmd_valid&cmd_ready at cycle N, register op/data → EXEC.
  - EXEC (cycle N+1): cmd_ready=0. Adder evaluates registered operands combinationally. At the end of the cycle, acc, rsp_data and rsp_overflow update → RESP.
  - RESP (from cycle N+2): rsp_valid=1, cmd_ready=0. rsp_data/rsp_overflow are held stable while rsp_valid&!rsp_ready. On rsp_ready → IDLE.
- Latency: command accept to rsp_valid is 2 cycles. No back-to-back overlap. Throughput is one command per 3 cycles when rsp_ready is held high.
- Adder operands:
  - ADD: a=acc, b=cmd_data.
  - SUB: a=acc, b=-cmd_data (two's-complement negation).
  - SUB with cmd_data = signed min (0x80000000 at WIDTH=32): the negation wraps. Overflow is then forced to (acc >= 0), and the result is acc - cmd_data mod 2^WIDTH, i.e. acc + 0x80000000.
- Per-op results:
  - LOAD: acc=cmd_data, rsp_overflow=0, sticky_ov unchanged.
  - CLEAR: acc=0, rsp_overflow=0, sticky_ov cleared to 0 in the same update.
  - ADD/SUB: rsp_overflow = adder overflow (or the forced value above). sticky_ov |= rsp_overflow.
- On overflow:
  - SATURATE=0: acc = wrapped sum.
  - SATURATE=1: acc = signed max if a ≥ 0, else signed min.
  - rsp_data always equals the new acc.
- Simultaneous events: cmd_valid during EXEC/RESP is ignored (cmd_ready=0) and must be held by the producer. rsp_ready while rsp_valid=0 has no effect.
- acc_value tracks acc, updating at the end of EXEC.

Decomposition:
- Package `calc_pkg`:
  - typedef `calc_op_e` (LOAD/ADD/SUB/CLEAR, 2-bit).
  - typedef `acc_state_e` (IDLE/EXEC/RESP).
  - constants `CALC_WIDTH=32`, `SMAX`/`SMIN` per width.
- Sub-module: instantiate the existing `adder` unchanged (a, b, sum, overflow). Negation and saturation muxing stay in this block.

Test Plan:
- Reset then LOAD 10 → rsp_valid at accept+2, rsp_data=10, rsp_overflow=0, sticky_ov=0; cmd_ready low for exactly 2 cycles plus the RESP wait.
- From acc=10: ADD 5 → 15; SUB 20 → -5; no overflow, sticky_ov=0.
- LOAD 0x7fffffff, ADD 1: SATURATE=0 → rsp_data=0x80000000, rsp_overflow=1, sticky_ov=1; SATURATE=1 → rsp_data=0x7fffffff, rsp_overflow=1.
- LOAD 0, SUB 0x80000000 → rsp_data=0x80000000, rsp_overflow=1. Then LOAD -1, SUB 0x80000000 → rsp_data=0x7fffffff, rsp_overflow=0.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP → rsp_data stable; a cmd_valid pulse is not accepted; CLEAR afterwards → acc=0, sticky_ov=0.
- Assert rst during EXEC of ADD 5 → next cycle IDLE, acc=0, rsp_valid=0, sticky_ov=0; no response emitted.

Source files
------------

// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : calc_pkg
//  Purpose  : Shared types and constants for the calc accumulator datapath.
//             Command opcodes, accumulator FSM states and the signed
//             max/min constants at the default datapath width.
//  Revision : 1.0  initial release
// ============================================================================
package calc_pkg;

    localparam int CALC_WIDTH = 32;

    localparam logic [CALC_WIDTH-1:0] SMAX = {1'b0, {(CALC_WIDTH-1){1'b1}}};
    localparam logic [CALC_WIDTH-1:0] SMIN = {1'b1, {(CALC_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        LOAD  = 2'b00,
        ADD   = 2'b01,
        SUB   = 2'b10,
        CLEAR = 2'b11
    } calc_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } acc_state_e;

endpackage : calc_pkg
`default_nettype wire

// File: rtl/adder.sv
`default_nettype none
// ============================================================================
//  Module   : adder
//  Purpose  : Signed two's-complement adder with overflow flag.
//  Ports    : a, b     - signed operands
//             sum      - a + b, wrapped to WIDTH bits
//             overflow - signed overflow of the addition
//  Revision : 1.0  initial release
// ============================================================================
module adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             overflow
);

    assign sum = a + b;

    // Overflow only when both operands share a sign and the result does not.
    assign overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule : adder
`default_nettype wire

// File: rtl/calc_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : calc_accumulator
//  Purpose  : Sequencing core of the calc datapath. Accepts LOAD/ADD/SUB/CLEAR
//             commands, drives the signed adder from the accumulator and the
//             command operand, latches the result and returns it over a
//             valid/ready response channel.
//  Ports    : clk, rst                   - clock, synchronous active-high reset
//             cmd_valid/cmd_ready        - command handshake
//             cmd_op, cmd_data           - opcode and signed operand
//             rsp_valid/rsp_ready        - response handshake
//             rsp_data, rsp_overflow     - accumulator after command, overflow
//             sticky_ov                  - overflow seen since CLEAR/reset
//             acc_value                  - live accumulator
//  Revision : 1.0  initial release
// ============================================================================
module calc_accumulator
    import calc_pkg::*;
#(
    parameter int WIDTH    = CALC_WIDTH,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_overflow,
    output logic             sticky_ov,
    output logic [WIDTH-1:0] acc_value
);

    localparam logic [WIDTH-1:0] c_smax = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_smin = {1'b1, {(WIDTH-1){1'b0}}};

    acc_state_e       r_state;
    acc_state_e       w_state_next;

    calc_op_e         r_op;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_rsp_data;
    logic             r_rsp_ov;
    logic             r_sticky;

    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_sum;
    logic             w_add_ov;
    logic             w_sub_min;
    logic             w_ov;
    logic [WIDTH-1:0] w_arith;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_rsp_ov_next;
    logic             w_sticky_next;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (cmd_valid) w_state_next = EXEC;
            EXEC:    w_state_next = RESP;
            RESP:    if (rsp_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        case (r_state)
            IDLE:    cmd_ready = 1'b1;
            RESP:    rsp_valid = 1'b1;
            default: begin
                cmd_ready = 1'b0;
                rsp_valid = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand path into the adder
    // ------------------------------------------------------------------
    assign w_b = (r_op == SUB) ? (~r_data + 1'b1) : r_data;

    adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a        (r_acc),
        .b        (w_b),
        .sum      (w_sum),
        .overflow (w_add_ov)
    );

    // Negating the signed minimum wraps back to itself, so the adder sees
    // acc + SMIN and its overflow flag is wrong. The true acc - SMIN
    // overflows exactly when acc is non-negative.
    assign w_sub_min = (r_op == SUB) && (r_data == c_smin);
    assign w_ov      = w_sub_min ? ~r_acc[WIDTH-1] : w_add_ov;

    generate
        if (SATURATE) begin : g_sat
            // Overflow direction follows the sign of the accumulator operand.
            assign w_arith = w_ov ? (r_acc[WIDTH-1] ? c_smin : c_smax) : w_sum;
        end else begin : g_wrap
            assign w_arith = w_sum;
        end
    endgenerate

    always_comb begin
        w_acc_next    = w_arith;
        w_rsp_ov_next = w_ov;
        w_sticky_next = r_sticky | w_ov;
        case (r_op)
            LOAD: begin
                w_acc_next    = r_data;
                w_rsp_ov_next = 1'b0;
                w_sticky_next = r_sticky;
            end
            CLEAR: begin
                w_acc_next    = '0;
                w_rsp_ov_next = 1'b0;
                w_sticky_next = 1'b0;
            end
            default: begin
                w_acc_next    = w_arith;
                w_rsp_ov_next = w_ov;
                w_sticky_next = r_sticky | w_ov;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op       <= LOAD;
            r_data     <= '0;
            r_acc      <= '0;
            r_rsp_data <= '0;
            r_rsp_ov   <= 1'b0;
            r_sticky   <= 1'b0;
        end else begin
            if ((r_state == IDLE) && cmd_valid) begin
                r_op   <= calc_op_e'(cmd_op);
                r_data <= cmd_data;
            end
            if (r_state == EXEC) begin
                r_acc      <= w_acc_next;
                r_rsp_data <= w_acc_next;
                r_rsp_ov   <= w_rsp_ov_next;
                r_sticky   <= w_sticky_next;
            end
        end
    end

    assign rsp_data     = r_rsp_data;
    assign rsp_overflow = r_rsp_ov;
    assign sticky_ov    = r_sticky;
    assign acc_value    = r_acc;

endmodule : calc_accumulator
`default_nettype wire

// File: tb/tb_calc_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_calc_accumulator
//  Purpose  : Self-checking bench for calc_accumulator. Two instances, one
//             wrapping and one saturating, share the same command stream;
//             expected responses are queued by the driver and compared by
//             an independent monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_calc_accumulator;
    import calc_pkg::*;

    typedef struct packed {
        logic [1:0][31:0] d;
        logic [1:0]       ov;
        logic [1:0]       st;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic [1:0]       cmd_op;
    logic [31:0]      cmd_data;
    logic             rsp_ready;

    logic [1:0]       cmd_ready_v;
    logic [1:0]       rsp_valid_v;
    logic [1:0][31:0] rsp_data_v;
    logic [1:0]       rsp_ov_v;
    logic [1:0]       sticky_v;
    logic [1:0][31:0] acc_v;

    exp_t             q[$];
    exp_t             mon_e;
    int               n_pass;
    int               n_total;

    calc_accumulator #(.WIDTH(32), .SATURATE(1'b0)) dut_wrap (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready_v[0]),
        .cmd_op       (cmd_op),
        .cmd_data     (cmd_data),
        .rsp_valid    (rsp_valid_v[0]),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data_v[0]),
        .rsp_overflow (rsp_ov_v[0]),
        .sticky_ov    (sticky_v[0]),
        .acc_value    (acc_v[0])
    );

    calc_accumulator #(.WIDTH(32), .SATURATE(1'b1)) dut_sat (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready_v[1]),
        .cmd_op       (cmd_op),
        .cmd_data     (cmd_data),
        .rsp_valid    (rsp_valid_v[1]),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data_v[1]),
        .rsp_overflow (rsp_ov_v[1]),
        .sticky_ov    (sticky_v[1]),
        .acc_value    (acc_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] d0, input logic o0, input logic s0,
                                input logic [31:0] d1, input logic o1, input logic s1);
        exp_t e;
        e.d[0] = d0; e.ov[0] = o0; e.st[0] = s0;
        e.d[1] = d1; e.ov[1] = o1; e.st[1] = s1;
        return e;
    endfunction

    // Monitor: while a response is presented it must match the queue head;
    // the head is retired only on the handshake, so backpressure is checked
    // for stability every cycle.
    always @(negedge clk) begin
        if (!rst && (rsp_valid_v != 2'b00)) begin
            chk("rsp_valid_both", {30'd0, rsp_valid_v}, 32'd3);
            if (q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_rsp: got data %h/%h expected no response (t=%0t)",
                         rsp_data_v[0], rsp_data_v[1], $time);
            end else begin
                mon_e = q[0];
                for (int i = 0; i < 2; i++) begin
                    chk($sformatf("rsp_data[%0d]", i), rsp_data_v[i], mon_e.d[i]);
                    chk($sformatf("rsp_ov[%0d]", i), {31'd0, rsp_ov_v[i]}, {31'd0, mon_e.ov[i]});
                    chk($sformatf("sticky[%0d]", i), {31'd0, sticky_v[i]}, {31'd0, mon_e.st[i]});
                    chk($sformatf("acc_value[%0d]", i), acc_v[i], mon_e.d[i]);
                end
                if (rsp_ready) void'(q.pop_front());
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic accept_cmd(input logic [1:0] op, input logic [31:0] data);
        int waited;
        cmd_op    = op;
        cmd_data  = data;
        cmd_valid = 1'b1;
        waited    = 0;
        while (!cmd_ready_v[0] && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("accept_timeout", {31'd0, (waited < 20)}, 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [31:0] data, input exp_t e);
        int waited;
        accept_cmd(op, data);
        q.push_back(e);
        chk("exec_cmd_ready", {30'd0, cmd_ready_v}, 32'd0);
        chk("exec_rsp_valid", {30'd0, rsp_valid_v}, 32'd0);
        @(posedge clk); #1;
        chk("latency_rsp_valid", {30'd0, rsp_valid_v}, 32'd3);
        chk("resp_cmd_ready", {30'd0, cmd_ready_v}, 32'd0);
        waited = 0;
        while (rsp_valid_v[0] && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("rsp_drain_timeout", {31'd0, (waited < 20)}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish by 100000");
        $fatal(1, "timeout");
    end

    initial begin
        n_pass    = 0;
        n_total   = 0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = 32'd0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_acc[%0d]", i), acc_v[i], 32'd0);
            chk($sformatf("rst_rsp_data[%0d]", i), rsp_data_v[i], 32'd0);
            chk($sformatf("rst_flags[%0d]", i),
                {28'd0, sticky_v[i], rsp_ov_v[i], rsp_valid_v[i], cmd_ready_v[i]}, 32'd1);
        end

        // Basic arithmetic, no overflow
        run_cmd(LOAD, 32'd10,         mk(32'd10, 0, 0, 32'd10, 0, 0));
        run_cmd(ADD,  32'd5,          mk(32'd15, 0, 0, 32'd15, 0, 0));
        run_cmd(SUB,  32'd20,         mk(32'hFFFF_FFFB, 0, 0, 32'hFFFF_FFFB, 0, 0));

        // Positive overflow: wrap vs clamp
        run_cmd(LOAD, 32'h7FFF_FFFF,  mk(32'h7FFF_FFFF, 0, 0, 32'h7FFF_FFFF, 0, 0));
        run_cmd(ADD,  32'd1,          mk(32'h8000_0000, 1, 1, 32'h7FFF_FFFF, 1, 1));

        // Subtracting the signed minimum
        run_cmd(LOAD, 32'd0,          mk(32'd0, 0, 1, 32'd0, 0, 1));
        run_cmd(SUB,  32'h8000_0000,  mk(32'h8000_0000, 1, 1, 32'h7FFF_FFFF, 1, 1));
        run_cmd(LOAD, 32'hFFFF_FFFF,  mk(32'hFFFF_FFFF, 0, 1, 32'hFFFF_FFFF, 0, 1));
        run_cmd(SUB,  32'h8000_0000,  mk(32'h7FFF_FFFF, 0, 1, 32'h7FFF_FFFF, 0, 1));

        // Backpressure: response held for 5 cycles, a stray command pulse ignored
        rsp_ready = 1'b0;
        accept_cmd(ADD, 32'd1);
        q.push_back(mk(32'h8000_0000, 1, 1, 32'h7FFF_FFFF, 1, 1));
        @(posedge clk); #1;
        chk("bp_rsp_valid", {30'd0, rsp_valid_v}, 32'd3);
        for (int k = 0; k < 5; k++) begin
            cmd_op    = LOAD;
            cmd_data  = 32'd123;
            cmd_valid = (k == 2);
            chk("bp_cmd_ready", {30'd0, cmd_ready_v}, 32'd0);
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_released", {30'd0, rsp_valid_v}, 32'd0);
        chk("bp_acc[0]", acc_v[0], 32'h8000_0000);
        chk("bp_acc[1]", acc_v[1], 32'h7FFF_FFFF);

        run_cmd(CLEAR, 32'hDEAD_BEEF, mk(32'd0, 0, 0, 32'd0, 0, 0));

        // Re-arm sticky, then reset in the middle of an ADD
        run_cmd(LOAD, 32'h7FFF_FFFF,  mk(32'h7FFF_FFFF, 0, 0, 32'h7FFF_FFFF, 0, 0));
        run_cmd(ADD,  32'd1,          mk(32'h8000_0000, 1, 1, 32'h7FFF_FFFF, 1, 1));
        accept_cmd(ADD, 32'd5);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("midrst_acc[%0d]", i), acc_v[i], 32'd0);
            chk($sformatf("midrst_flags[%0d]", i),
                {29'd0, sticky_v[i], rsp_valid_v[i], cmd_ready_v[i]}, 32'd1);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_no_rsp", {30'd0, rsp_valid_v}, 32'd0);

        run_cmd(LOAD, 32'd42,         mk(32'd42, 0, 0, 32'd42, 0, 0));

        chk("queue_empty", q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_calc_accumulator
`default_nettype wire
